// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction round sequencer and its stats accumulator.
// The optional average path is enabled with the REACTION_AVG_EN macro.
package reaction_pkg;

    localparam int TIME_W       = 14;
    localparam int IDX_W        = 4;
    localparam int MAX_TIME_DEF = 1000;

    localparam logic [1:0] DISP_ROUND = 2'd0;
    localparam logic [1:0] DISP_BEST  = 2'd1;
    localparam logic [1:0] DISP_AVG   = 2'd2;
    localparam logic [1:0] DISP_BLANK = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_LOAD,
        ST_CONV_REQ,
        ST_CONV_WAIT,
        ST_SHOW,
        ST_SUMMARY
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/reaction_round_sequencer_if.sv
// Bundle of the sequencer's command, timer and BCD converter signals.
// master = environment side (buttons, timer, converter), slave = sequencer side.
interface reaction_round_sequencer_if;
    import reaction_pkg::*;

    logic              start;
    logic              clear;
    logic              result_valid;
    logic              result_fault;
    logic [TIME_W-1:0] result_time;
    logic              bcd_ready;
    logic              bcd_done_tick;
    logic              timer_start;
    logic              timer_clear;
    logic              bcd_start;
    logic [TIME_W-1:0] bcd_bin;
    logic [1:0]        disp_sel;
    logic [IDX_W-1:0]  round_idx;
    logic              busy;
    logic              session_done;

    modport master (
        output start, clear, result_valid, result_fault, result_time, bcd_ready, bcd_done_tick,
        input  timer_start, timer_clear, bcd_start, bcd_bin, disp_sel, round_idx, busy, session_done
    );

    modport slave (
        input  start, clear, result_valid, result_fault, result_time, bcd_ready, bcd_done_tick,
        output timer_start, timer_clear, bcd_start, bcd_bin, disp_sel, round_idx, busy, session_done
    );

endinterface

// File: rtl/reaction_stats_acc.sv
// Per-session statistics: best (minimum non-faulted) time and, with REACTION_AVG_EN,
// a sum accumulator whose average is the sum divided by the (power-of-two) round count.
module reaction_stats_acc
    import reaction_pkg::*;
`ifdef REACTION_AVG_EN
#(
    parameter int NUM_ROUNDS = 4
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              update_i,
    input  logic              fault_i,
    input  logic [TIME_W-1:0] time_i,
`ifdef REACTION_AVG_EN
    output logic [TIME_W-1:0] avg_o,
`endif
    output logic [TIME_W-1:0] best_o
);

    logic [TIME_W-1:0] best_q;

    // Strict less-than: a tie keeps the value already held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= '1;
        end else if (clr_i) begin
            best_q <= '1;
        end else if (update_i && !fault_i && (time_i < best_q)) begin
            best_q <= time_i;
        end
    end

    assign best_o = best_q;

`ifdef REACTION_AVG_EN
    localparam int SHIFT = clog2(NUM_ROUNDS);
    localparam int SUM_W = TIME_W + SHIFT;

    logic [SUM_W-1:0] sum_q;

    // time_i already carries the fault substitute value, so faulted rounds add it too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (clr_i) begin
            sum_q <= '0;
        end else if (update_i) begin
            sum_q <= sum_q + SUM_W'(time_i);
        end
    end

    assign avg_o = sum_q[SUM_W-1:SHIFT];
`endif

endmodule

// File: rtl/reaction_round_sequencer.sv
// Session controller: runs NUM_ROUNDS reaction trials, shows each result, then cycles a summary.
// Define REACTION_AVG_EN to add the average page alongside the best page.
module reaction_round_sequencer
    import reaction_pkg::*;
#(
    parameter int NUM_ROUNDS    = 4,
    parameter int SHOW_TICKS    = 50_000_000,
    parameter int SUMMARY_TICKS = 100_000_000,
    parameter int MAX_TIME      = MAX_TIME_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    reaction_round_sequencer_if.slave  bus
);

    localparam int MAX_TICKS = (SHOW_TICKS > SUMMARY_TICKS) ? SHOW_TICKS : SUMMARY_TICKS;
    localparam int CNT_W     = (clog2(MAX_TICKS) < 1) ? 1 : clog2(MAX_TICKS);
    localparam logic [TIME_W-1:0] MAX_TIME_V = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] BEST_INIT  = '1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  round_q, round_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              summary_q, summary_d;
    logic              page_q, page_d;
    logic [TIME_W-1:0] bin_q, bin_d;
    logic [TIME_W-1:0] res_time_q, res_time_d;
    logic              res_fault_q, res_fault_d;
    logic              timer_clear_q, timer_clear_d;

    logic              stats_clr, stats_upd;
    logic              timer_start, bcd_start;
    logic [TIME_W-1:0] round_val, best, best_disp;
    logic [1:0]        disp_sel;
`ifdef REACTION_AVG_EN
    logic [TIME_W-1:0] avg;
`endif

    reaction_stats_acc
`ifdef REACTION_AVG_EN
        #(.NUM_ROUNDS(NUM_ROUNDS))
`endif
    u_stats (
        .clk      (clk),
        .rst_n    (reset_n),
        .clr_i    (stats_clr),
        .update_i (stats_upd),
        .fault_i  (res_fault_q),
        .time_i   (round_val),
`ifdef REACTION_AVG_EN
        .avg_o    (avg),
`endif
        .best_o   (best)
    );

    // NOTE: every variable driven here gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        summary_d     = summary_q;
        page_d        = page_q;
        bin_d         = bin_q;
        res_time_d    = res_time_q;
        res_fault_d   = res_fault_q;
        timer_clear_d = 1'b0;
        stats_clr     = 1'b0;
        stats_upd     = 1'b0;
        timer_start   = 1'b0;
        bcd_start     = 1'b0;
        round_val     = res_fault_q ? MAX_TIME_V : res_time_q;
        best_disp     = (best == BEST_INIT) ? MAX_TIME_V : best;

        if (bus.clear) begin
            state_d       = ST_IDLE;
            round_d       = '0;
            summary_d     = 1'b0;
            page_d        = 1'b0;
            bin_d         = '0;
            timer_clear_d = 1'b1;
            stats_clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    state_d   = ST_ARM;
                    round_d   = '0;
                    stats_clr = 1'b1;
                end
                ST_ARM: begin
                    timer_start = 1'b1;
                    state_d     = ST_WAIT;
                end
                ST_WAIT: if (bus.result_valid) begin
                    res_time_d  = bus.result_time;
                    res_fault_d = bus.result_fault;
                    state_d     = ST_LOAD;
                end
                ST_LOAD: begin
                    stats_upd = 1'b1;
                    bin_d     = round_val;
                    state_d   = ST_CONV_REQ;
                end
                ST_CONV_REQ: if (bus.bcd_ready) begin
                    bcd_start = 1'b1;
                    state_d   = ST_CONV_WAIT;
                end
                ST_CONV_WAIT: if (bus.bcd_done_tick) begin
                    state_d = summary_q ? ST_SUMMARY : ST_SHOW;
                end
                ST_SHOW: if (cnt_q == '0) begin
                    if (round_q == IDX_W'(NUM_ROUNDS - 1)) begin
                        summary_d = 1'b1;
                        page_d    = 1'b0;
                        bin_d     = best_disp;
                        state_d   = ST_CONV_REQ;
                    end else begin
                        round_d = round_q + 1'b1;
                        state_d = ST_ARM;
                    end
                end
                ST_SUMMARY: begin
                    if (bus.start) begin
                        summary_d = 1'b0;
                        page_d    = 1'b0;
                        round_d   = '0;
                        stats_clr = 1'b1;
                        state_d   = ST_ARM;
                    end
`ifdef REACTION_AVG_EN
                    else if (cnt_q == '0) begin
                        page_d  = !page_q;
                        bin_d   = page_q ? best_disp : avg;
                        state_d = ST_CONV_REQ;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Shared hold counter reloads on every state change and only matters in SHOW/SUMMARY.
        if (state_d != state_q) begin
            cnt_d = (state_d == ST_SUMMARY) ? CNT_W'(SUMMARY_TICKS - 1) : CNT_W'(SHOW_TICKS - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        if (summary_q) begin
            disp_sel = page_q ? DISP_AVG : DISP_BEST;
        end else if (state_q == ST_SHOW) begin
            disp_sel = DISP_ROUND;
        end else begin
            disp_sel = DISP_BLANK;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            round_q       <= '0;
            cnt_q         <= '0;
            summary_q     <= 1'b0;
            page_q        <= 1'b0;
            bin_q         <= '0;
            res_time_q    <= '0;
            res_fault_q   <= 1'b0;
            timer_clear_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            cnt_q         <= cnt_d;
            summary_q     <= summary_d;
            page_q        <= page_d;
            bin_q         <= bin_d;
            res_time_q    <= res_time_d;
            res_fault_q   <= res_fault_d;
            timer_clear_q <= timer_clear_d;
        end
    end

    assign bus.timer_start  = timer_start;
    assign bus.timer_clear  = timer_clear_q;
    assign bus.bcd_start    = bcd_start;
    assign bus.bcd_bin      = bin_q;
    assign bus.disp_sel     = disp_sel;
    assign bus.round_idx    = round_q;
    assign bus.busy         = (state_q != ST_IDLE) && !summary_q;
    assign bus.session_done = summary_q;

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Directed bench for reaction_round_sequencer with a converter responder and a bcd_bin scoreboard.
// Average expectations are added when REACTION_AVG_EN is defined.
module tb_reaction_round_sequencer;
    import reaction_pkg::*;

    localparam int N     = 4;
    localparam int TICKS = 8;
    localparam int MAXT  = 1000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    reaction_round_sequencer_if bus();

    reaction_round_sequencer #(
        .NUM_ROUNDS    (N),
        .SHOW_TICKS    (TICKS),
        .SUMMARY_TICKS (TICKS),
        .MAX_TIME      (MAXT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks   = 0;
    int n_fail     = 0;
    int ts_count   = 0;
    int cvt_count  = 0;
    int done_count = 0;
    int pushed     = 0;
    int exp_q[$];
    int model_best;
    int model_sum;
    int ts_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) if (bus.timer_start === 1'b1) ts_count++;

    // Converter model: on each bcd_start, score bcd_bin, hold it steady, then pulse done.
    initial begin
        logic [TIME_W-1:0] held;
        int exp;
        bus.bcd_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.bcd_start === 1'b1) begin
                cvt_count++;
                held = bus.bcd_bin;
                exp  = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                check("bcd_bin", 32'(bus.bcd_bin), exp);
                @(posedge clk); #1;
                check("bcd_start_width", 32'(bus.bcd_start), 0);
                @(posedge clk); #1;
                check("bin_stable", 32'(bus.bcd_bin), 32'(held));
                @(posedge clk); #1;
                bus.bcd_done_tick = 1'b1;
                @(posedge clk); #1;
                bus.bcd_done_tick = 1'b0;
                done_count++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        model_best = 16383;
        model_sum  = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
    endtask

    task automatic start_session();
        pulse_start();
        check("timer_start_latency", 32'(bus.timer_start), 1);
        model_reset();
    endtask

    task automatic send_result(input bit fault, input int t, input bit push);
        int v;
        v = fault ? MAXT : t;
        if (push) begin
            exp_q.push_back(v);
            pushed++;
        end
        if (!fault && t < model_best) model_best = t;
        model_sum += v;
        bus.result_fault = fault;
        bus.result_time  = TIME_W'(t);
        bus.result_valid = 1'b1;
        tick(1);
        bus.result_valid = 1'b0;
        bus.result_fault = 1'b0;
    endtask

    task automatic push_summary();
        int b;
        b = (model_best == 16383) ? MAXT : model_best;
        exp_q.push_back(b);
        pushed++;
`ifdef REACTION_AVG_EN
        exp_q.push_back(model_sum / N);
        exp_q.push_back(b);
        pushed += 2;
`endif
    endtask

    task automatic wait_ts();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.timer_start === 1'b1) found = 1'b1;
        end
        check("timer_start_seen", 32'(found), 1);
    endtask

    task automatic wait_show(input int idx);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.disp_sel === DISP_ROUND) found = 1'b1;
        end
        check("show_seen", 32'(found), 1);
        check("round_idx", 32'(bus.round_idx), idx);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600 && done_count != pushed; i++) @(negedge clk);
        check("conv_count", done_count, pushed);
    endtask

    task automatic drive_round(input bit fault, input int t, input int idx);
        wait_ts();
        tick(3);
        send_result(fault, t, 1'b1);
        wait_show(idx);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.clear        = 1'b0;
        bus.result_valid = 1'b0;
        bus.result_fault = 1'b0;
        bus.result_time  = '0;
        bus.bcd_ready    = 1'b1;
        model_reset();

        reset_n = 1'b0;
        tick(3);
        check("rst_disp", 32'(bus.disp_sel), 3);
        check("rst_bin", 32'(bus.bcd_bin), 0);
        check("rst_round", 32'(bus.round_idx), 0);
        check("rst_flags", 32'({bus.timer_start, bus.timer_clear, bus.bcd_start, bus.busy, bus.session_done}), 0);
        reset_n = 1'b1;
        tick(2);
        check("idle_disp", 32'(bus.disp_sel), 3);

        // Session 1: 250,300,200,350 -> best 200, avg 275
        start_session();
        check("busy_run", 32'(bus.busy), 1);
        drive_round(1'b0, 250, 0);
        drive_round(1'b0, 300, 1);
        drive_round(1'b0, 200, 2);
        drive_round(1'b0, 350, 3);
        push_summary();
        wait_done();
        check("session_done", 32'(bus.session_done), 1);
        check("busy_summary", 32'(bus.busy), 0);
        check("summary_disp", 32'(bus.disp_sel), 1);
`ifndef REACTION_AVG_EN
        tick(20);
        check("summary_once", cvt_count, pushed);
        check("summary_disp_hold", 32'(bus.disp_sel), 1);
`endif

        // Session 2 started from SUMMARY: 400,fault,120,fault -> best 120, avg 630
        start_session();
        check("session_done_clr", 32'(bus.session_done), 0);
        check("round_idx_restart", 32'(bus.round_idx), 0);
        drive_round(1'b0, 400, 0);
        drive_round(1'b1, 5000, 1);
        drive_round(1'b0, 120, 2);
        drive_round(1'b1, 30, 3);
        push_summary();
        wait_done();
        check("summary2_disp", 32'(bus.disp_sel), 1);

        // Clear out of SUMMARY
        pulse_clear();
        check("timer_clear_pulse", 32'(bus.timer_clear), 1);
        check("clear_disp", 32'(bus.disp_sel), 3);
        check("clear_done", 32'(bus.session_done), 0);
        tick(1);
        check("timer_clear_width", 32'(bus.timer_clear), 0);

        // Start and clear in the same cycle: clear wins
        ts_b = ts_count;
        bus.start = 1'b1;
        bus.clear = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.clear = 1'b0;
        tick(3);
        check("start_clear_no_ts", ts_count, ts_b);
        check("start_clear_busy", 32'(bus.busy), 0);

        // Session 3: converter busy for 10 cycles on round 0
        start_session();
        wait_ts();
        tick(3);
        bus.bcd_ready = 1'b0;
        send_result(1'b0, 500, 1'b1);
        tick(10);
        check("ready_hold_conv", cvt_count, pushed - 1);
        check("ready_hold_start", 32'(bus.bcd_start), 0);
        bus.bcd_ready = 1'b1;
        wait_show(0);

        // Round 1: start during WAIT is ignored
        wait_ts();
        tick(2);
        ts_b = ts_count;
        pulse_start();
        tick(2);
        check("wait_start_no_ts", ts_count, ts_b);
        check("wait_start_idx", 32'(bus.round_idx), 1);
        send_result(1'b0, 600, 1'b1);
        wait_show(1);

        // Round 2: clear while the conversion is pending
        wait_ts();
        tick(3);
        bus.bcd_ready = 1'b0;
        send_result(1'b0, 700, 1'b0);
        tick(3);
        pulse_clear();
        check("conv_clear_pulse", 32'(bus.timer_clear), 1);
        check("conv_clear_disp", 32'(bus.disp_sel), 3);
        check("conv_clear_idx", 32'(bus.round_idx), 0);
        check("conv_clear_busy", 32'(bus.busy), 0);
        bus.bcd_ready = 1'b1;
        tick(5);
        check("conv_clear_no_start", cvt_count, pushed);

        // Session 4: every round faulted -> best shows MAX_TIME
        start_session();
        drive_round(1'b1, 90, 0);
        drive_round(1'b1, 90, 1);
        drive_round(1'b1, 4000, 2);
        drive_round(1'b1, 10, 3);
        push_summary();
        wait_done();
        check("fault_summary_disp", 32'(bus.disp_sel), 1);

        // Session 5: async reset in the middle of SHOW
        start_session();
        drive_round(1'b0, 777, 0);
        tick(2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_disp", 32'(bus.disp_sel), 3);
        check("mid_rst_bin", 32'(bus.bcd_bin), 0);
        check("mid_rst_round", 32'(bus.round_idx), 0);
        check("mid_rst_flags", 32'({bus.timer_start, bus.timer_clear, bus.bcd_start, bus.busy, bus.session_done}), 0);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        check("mid_rst_idle_busy", 32'(bus.busy), 0);
        check("sb_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
